// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single L2 port between the L1 I-cache and the
// L1 D-cache. One whole line transaction is granted at a time, and resp/rdata
// are routed back to the granted requester only.
// Contention is resolved round-robin by default. Define ARB_FIXED_DPRIO_EN to
// make the D-cache always win ties; the last_grant register then disappears.

module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic [ADDR_W-1:0] i_pmem_address,
  input  logic              i_pmem_read,
  input  logic              i_pmem_write,
  input  logic [LINE_W-1:0] i_pmem_wdata,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,

  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,

  output logic [ADDR_W-1:0] l2_address,
  output logic              l2_read,
  output logic              l2_write,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,

  output logic [1:0]        arb_grant
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic req_i;
  logic req_d;
  logic d_wins_tie;

  assign req_i = i_pmem_read | i_pmem_write;
  assign req_d = d_pmem_read | d_pmem_write;

`ifdef ARB_FIXED_DPRIO_EN
  assign d_wins_tie = 1'b1;
`else
  // last_grant: 0 = I-cache served last, 1 = D-cache served last.
  logic last_grant;

  // Remember who completed the most recent transaction so the other side wins the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b0;
    end else if (l2_resp && (state == SERVE_I)) begin
      last_grant <= 1'b0;
    end else if (l2_resp && (state == SERVE_D)) begin
      last_grant <= 1'b1;
    end
  end

  assign d_wins_tie = ~last_grant;
`endif

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: grant from IDLE, return to IDLE on completion or when the owner withdraws.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_i && req_d) begin
          next_state = d_wins_tie ? SERVE_D : SERVE_I;
        end else if (req_i) begin
          next_state = SERVE_I;
        end else if (req_d) begin
          next_state = SERVE_D;
        end
      end
      SERVE_I: begin
        if (l2_resp || !req_i) begin
          next_state = IDLE;
        end
      end
      SERVE_D: begin
        if (l2_resp || !req_d) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs: pass the owner's live request to L2 and forward the L2 response only to the owner.
  always_comb begin
    l2_address   = '0;
    l2_read      = 1'b0;
    l2_write     = 1'b0;
    l2_wdata     = '0;
    i_pmem_resp  = 1'b0;
    i_pmem_rdata = '0;
    d_pmem_resp  = 1'b0;
    d_pmem_rdata = '0;
    arb_grant    = 2'b00;
    case (state)
      SERVE_I: begin
        arb_grant   = 2'b01;
        l2_address  = i_pmem_address;
        l2_write    = i_pmem_write;
        l2_read     = i_pmem_read & ~i_pmem_write;
        l2_wdata    = i_pmem_wdata;
        i_pmem_resp = l2_resp;
        if (l2_resp) begin
          i_pmem_rdata = l2_rdata;
        end
      end
      SERVE_D: begin
        arb_grant   = 2'b10;
        l2_address  = d_pmem_address;
        l2_write    = d_pmem_write;
        l2_read     = d_pmem_read & ~d_pmem_write;
        l2_wdata    = d_pmem_wdata;
        d_pmem_resp = l2_resp;
        if (l2_resp) begin
          d_pmem_rdata = l2_rdata;
        end
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: self-checking bench for cache_arbiter with a small L2
// responder and a scoreboard of expected L2 transactions in grant order.

module tb_cache_arbiter;

  logic         clk;
  logic         rst_n;
  logic [15:0]  i_pmem_address;
  logic         i_pmem_read;
  logic         i_pmem_write;
  logic [127:0] i_pmem_wdata;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic [15:0]  d_pmem_address;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic [15:0]  l2_address;
  logic         l2_read;
  logic         l2_write;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;
  logic [1:0]   arb_grant;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    bit          port_d;
    logic [15:0] addr;
    bit          wr;
  } txn_t;

  txn_t exp_q[$];

  cache_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_pmem_address(i_pmem_address),
    .i_pmem_read(i_pmem_read),
    .i_pmem_write(i_pmem_write),
    .i_pmem_wdata(i_pmem_wdata),
    .i_pmem_rdata(i_pmem_rdata),
    .i_pmem_resp(i_pmem_resp),
    .d_pmem_address(d_pmem_address),
    .d_pmem_read(d_pmem_read),
    .d_pmem_write(d_pmem_write),
    .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata),
    .d_pmem_resp(d_pmem_resp),
    .l2_address(l2_address),
    .l2_read(l2_read),
    .l2_write(l2_write),
    .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata),
    .l2_resp(l2_resp),
    .arb_grant(arb_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // L2 model: responds l2_lat cycles after a request appears, data derived from the address.
  logic         l2_resp_q = 1'b0;
  logic [127:0] l2_rdata_q = '0;
  logic         stray_resp = 1'b0;
  logic [127:0] stray_data = '0;
  int           l2_cnt = 0;
  int           l2_lat = 3;

  assign l2_resp  = l2_resp_q | stray_resp;
  assign l2_rdata = l2_rdata_q | stray_data;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      l2_resp_q  = 1'b0;
      l2_rdata_q = '0;
      l2_cnt     = 0;
    end else if (l2_resp_q) begin
      l2_resp_q  = 1'b0;
      l2_rdata_q = '0;
      l2_cnt     = 0;
    end else if (l2_read || l2_write) begin
      if (l2_cnt == l2_lat) begin
        l2_resp_q  = 1'b1;
        l2_rdata_q = {8{l2_address ^ 16'hD8CE}};
      end else begin
        l2_cnt++;
      end
    end else begin
      l2_cnt = 0;
    end
  end

  // Scoreboard: every forwarded L2 completion must match the next expected transaction.
  txn_t         mon_e;
  logic [1:0]   mon_grant;
  logic [127:0] mon_data;
  logic [127:0] mon_wdata;

  always @(negedge clk) begin
    if (rst_n && l2_resp && (arb_grant != 2'b00)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fails++;
        $display("[TB] FAIL unexpected_txn: grant=%b addr=%h with empty scoreboard", arb_grant, l2_address);
      end else begin
        mon_e     = exp_q.pop_front();
        mon_grant = mon_e.port_d ? 2'b10 : 2'b01;
        mon_data  = {8{mon_e.addr ^ 16'hD8CE}};
        mon_wdata = mon_e.port_d ? {8{~mon_e.addr}} : {8{mon_e.addr}};
        if (arb_grant !== mon_grant) begin
          n_fails++;
          $display("[TB] FAIL sb_grant: got %b expected %b", arb_grant, mon_grant);
        end
        n_checks++;
        if (l2_address !== mon_e.addr) begin
          n_fails++;
          $display("[TB] FAIL sb_address: got %h expected %h", l2_address, mon_e.addr);
        end
        n_checks++;
        if ({l2_read, l2_write} !== {~mon_e.wr, mon_e.wr}) begin
          n_fails++;
          $display("[TB] FAIL sb_rw: got %b%b expected %b%b", l2_read, l2_write, ~mon_e.wr, mon_e.wr);
        end
        n_checks++;
        if (mon_e.wr && (l2_wdata !== mon_wdata)) begin
          n_fails++;
          $display("[TB] FAIL sb_wdata: got %h expected %h", l2_wdata, mon_wdata);
        end
        n_checks++;
        if ({d_pmem_resp, i_pmem_resp} !== mon_grant) begin
          n_fails++;
          $display("[TB] FAIL sb_resp: got d=%b i=%b expected %b", d_pmem_resp, i_pmem_resp, mon_grant);
        end
        n_checks++;
        if ((mon_e.port_d ? d_pmem_rdata : i_pmem_rdata) !== mon_data) begin
          n_fails++;
          $display("[TB] FAIL sb_rdata: got %h expected %h", mon_e.port_d ? d_pmem_rdata : i_pmem_rdata, mon_data);
        end
        n_checks++;
        if ((mon_e.port_d ? i_pmem_rdata : d_pmem_rdata) !== 128'd0) begin
          n_fails++;
          $display("[TB] FAIL sb_other_rdata: got %h expected 0", mon_e.port_d ? i_pmem_rdata : d_pmem_rdata);
        end
      end
    end
  end

  task automatic set_i(input logic rd, input logic wr, input logic [15:0] a);
    i_pmem_read    = rd;
    i_pmem_write   = wr;
    i_pmem_address = a;
    i_pmem_wdata   = {8{a}};
  endtask

  task automatic set_d(input logic rd, input logic wr, input logic [15:0] a);
    d_pmem_read    = rd;
    d_pmem_write   = wr;
    d_pmem_address = a;
    d_pmem_wdata   = {8{~a}};
  endtask

  task automatic push_exp(input bit pd, input logic [15:0] a, input bit wr);
    txn_t t;
    t.port_d = pd;
    t.addr   = a;
    t.wr     = wr;
    exp_q.push_back(t);
  endtask

  task automatic wait_resp(output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      cycles++;
      if (i_pmem_resp || d_pmem_resp) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    set_i(1'b0, 1'b0, 16'h0);
    set_d(1'b0, 1'b0, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    set_i(1'b1, 1'b0, 16'h1111);
    set_d(1'b0, 1'b1, 16'h2222);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (arb_grant !== 2'b00) begin
      n_fails++;
      $display("[TB] FAIL reset_grant: got %b expected 00", arb_grant);
    end
    n_checks++;
    if ({l2_read, l2_write, l2_address, l2_wdata} !== '0) begin
      n_fails++;
      $display("[TB] FAIL reset_l2: got rd=%b wr=%b addr=%h expected all 0", l2_read, l2_write, l2_address);
    end
    n_checks++;
    if ({i_pmem_resp, d_pmem_resp, i_pmem_rdata, d_pmem_rdata} !== '0) begin
      n_fails++;
      $display("[TB] FAIL reset_resp: got i=%b d=%b expected 0", i_pmem_resp, d_pmem_resp);
    end
    apply_reset();
    n_checks++;
    if (arb_grant !== 2'b00) begin
      n_fails++;
      $display("[TB] FAIL idle_after_reset: got %b expected 00", arb_grant);
    end
  endtask

  task automatic test_stray_resp();
    stray_resp = 1'b1;
    stray_data = {8{16'hBEEF}};
    #1;
    n_checks++;
    if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin
      n_fails++;
      $display("[TB] FAIL stray_resp: got i=%b d=%b expected 00", i_pmem_resp, d_pmem_resp);
    end
    n_checks++;
    if ({i_pmem_rdata, d_pmem_rdata} !== '0) begin
      n_fails++;
      $display("[TB] FAIL stray_rdata: got %h / %h expected 0", i_pmem_rdata, d_pmem_rdata);
    end
    @(posedge clk);
    #1;
    stray_resp = 1'b0;
    stray_data = '0;
    n_checks++;
    if (arb_grant !== 2'b00) begin
      n_fails++;
      $display("[TB] FAIL stray_grant: got %b expected 00", arb_grant);
    end
  endtask

  task automatic test_lone_read();
    int cyc;
    bit ok;
    set_i(1'b1, 1'b0, 16'h1230);
    push_exp(1'b0, 16'h1230, 1'b0);
    #1;
    n_checks++;
    if (l2_read !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL lone_latency_early: got l2_read=%b expected 0", l2_read);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({arb_grant, l2_read, l2_address} !== {2'b01, 1'b1, 16'h1230}) begin
      n_fails++;
      $display("[TB] FAIL lone_grant: got grant=%b rd=%b addr=%h expected 01 1 1230", arb_grant, l2_read, l2_address);
    end
    wait_resp(cyc, ok);
    n_checks++;
    if (!ok || cyc != 4) begin
      n_fails++;
      $display("[TB] FAIL lone_resp_timing: got ok=%0d cycles=%0d expected ok=1 cycles=4", ok, cyc);
    end
    n_checks++;
    if (i_pmem_rdata[15:0] !== 16'hCAFE || d_pmem_resp !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL lone_rdata: got %h d_resp=%b expected CAFE 0", i_pmem_rdata[15:0], d_pmem_resp);
    end
    @(posedge clk);
    #1;
    set_i(1'b0, 1'b0, 16'h0);
    n_checks++;
    if ({arb_grant, i_pmem_resp, l2_read} !== 4'b0000) begin
      n_fails++;
      $display("[TB] FAIL lone_release: got grant=%b resp=%b rd=%b expected 0", arb_grant, i_pmem_resp, l2_read);
    end
  endtask

  task automatic test_simultaneous();
    int cyc;
    bit ok;
    apply_reset();
    set_i(1'b1, 1'b0, 16'h0040);
    set_d(1'b0, 1'b1, 16'h8000);
    push_exp(1'b1, 16'h8000, 1'b1);
    push_exp(1'b0, 16'h0040, 1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if ({arb_grant, l2_write, l2_address} !== {2'b10, 1'b1, 16'h8000}) begin
      n_fails++;
      $display("[TB] FAIL tie_first: got grant=%b wr=%b addr=%h expected 10 1 8000", arb_grant, l2_write, l2_address);
    end
    wait_resp(cyc, ok);
    n_checks++;
    if (!ok || d_pmem_resp !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL tie_d_resp: got ok=%0d d_resp=%b expected 1 1", ok, d_pmem_resp);
    end
    @(posedge clk);
    #1;
    set_d(1'b0, 1'b0, 16'h0);
    n_checks++;
    if ({arb_grant, l2_read, l2_write} !== 4'b0000) begin
      n_fails++;
      $display("[TB] FAIL tie_gap: got grant=%b rd=%b wr=%b expected idle", arb_grant, l2_read, l2_write);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({arb_grant, l2_read, l2_address} !== {2'b01, 1'b1, 16'h0040}) begin
      n_fails++;
      $display("[TB] FAIL tie_second: got grant=%b rd=%b addr=%h expected 01 1 0040", arb_grant, l2_read, l2_address);
    end
    wait_resp(cyc, ok);
    n_checks++;
    if (!ok) begin
      n_fails++;
      $display("[TB] FAIL tie_i_timeout: got no resp expected resp");
    end
    @(posedge clk);
    #1;
    set_i(1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_abort();
    int cyc;
    bit ok;
    set_i(1'b1, 1'b0, 16'h0300);
    @(posedge clk);
    #1;
    n_checks++;
    if (arb_grant !== 2'b01) begin
      n_fails++;
      $display("[TB] FAIL abort_grant_i: got %b expected 01", arb_grant);
    end
    set_i(1'b0, 1'b0, 16'h0300);
    set_d(1'b1, 1'b0, 16'h0500);
    push_exp(1'b1, 16'h0500, 1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if ({arb_grant, l2_read} !== 3'b000) begin
      n_fails++;
      $display("[TB] FAIL abort_idle: got grant=%b rd=%b expected 00 0", arb_grant, l2_read);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({arb_grant, l2_address} !== {2'b10, 16'h0500}) begin
      n_fails++;
      $display("[TB] FAIL abort_grant_d: got grant=%b addr=%h expected 10 0500", arb_grant, l2_address);
    end
    wait_resp(cyc, ok);
    n_checks++;
    if (!ok || i_pmem_resp !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL abort_d_resp: got ok=%0d i_resp=%b expected 1 0", ok, i_pmem_resp);
    end
    @(posedge clk);
    #1;
    set_d(1'b0, 1'b0, 16'h0);
  endtask

  task automatic test_fairness();
    int  cyc;
    bit  ok;
    bit  served_d;
    int  ki;
    int  kd;
    apply_reset();
`ifdef ARB_FIXED_DPRIO_EN
    for (int k = 0; k < 6; k++) begin
      push_exp(1'b1, 16'h2000 + 16'(k * 16), k[0]);
    end
`else
    for (int k = 0; k < 3; k++) begin
      push_exp(1'b1, 16'h2000 + 16'(k * 16), k[0]);
      push_exp(1'b0, 16'h1000 + 16'(k * 16), 1'b0);
    end
`endif
    ki = 0;
    kd = 0;
    set_i(1'b1, 1'b0, 16'h1000);
    set_d(1'b1, 1'b0, 16'h2000);
    for (int t = 0; t < 6; t++) begin
      wait_resp(cyc, ok);
      n_checks++;
      if (!ok) begin
        n_fails++;
        $display("[TB] FAIL fair_timeout: transaction %0d got no resp", t);
        break;
      end
      served_d = d_pmem_resp;
      @(posedge clk);
      #1;
      if (t == 5) begin
        set_i(1'b0, 1'b0, 16'h0);
        set_d(1'b0, 1'b0, 16'h0);
      end else if (served_d) begin
        kd++;
        set_d((kd % 2 == 0) || (kd == 1), kd % 2 == 1, 16'h2000 + 16'(kd * 16));
      end else begin
        ki++;
        set_i(1'b1, 1'b0, 16'h1000 + 16'(ki * 16));
      end
    end
    set_i(1'b0, 1'b0, 16'h0);
    set_d(1'b0, 1'b0, 16'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit ok;
    set_d(1'b0, 1'b1, 16'h4440);
    @(posedge clk);
    #1;
    n_checks++;
    if ({arb_grant, l2_write} !== 3'b101) begin
      n_fails++;
      $display("[TB] FAIL mid_grant: got grant=%b wr=%b expected 10 1", arb_grant, l2_write);
    end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({arb_grant, l2_write, i_pmem_resp, d_pmem_resp} !== 5'b00000) begin
      n_fails++;
      $display("[TB] FAIL mid_reset: got grant=%b wr=%b i=%b d=%b expected 0", arb_grant, l2_write, i_pmem_resp, d_pmem_resp);
    end
    set_d(1'b0, 1'b0, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_i(1'b1, 1'b0, 16'h0B00);
    set_d(1'b1, 1'b0, 16'h0A00);
    push_exp(1'b1, 16'h0A00, 1'b0);
    push_exp(1'b0, 16'h0B00, 1'b0);
    @(posedge clk);
    #1;
    n_checks++;
    if (arb_grant !== 2'b10) begin
      n_fails++;
      $display("[TB] FAIL mid_first_tie: got %b expected 10", arb_grant);
    end
    wait_resp(cyc, ok);
    @(posedge clk);
    #1;
    set_d(1'b0, 1'b0, 16'h0);
    wait_resp(cyc, ok);
    n_checks++;
    if (!ok || i_pmem_resp !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL mid_second: got ok=%0d i_resp=%b expected 1 1", ok, i_pmem_resp);
    end
    @(posedge clk);
    #1;
    set_i(1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_stray_resp();
    test_lone_read();
    test_simultaneous();
    test_abort();
    test_fairness();
    test_reset_mid();
    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port arbiter that shares the single L2 cache port between the L1 instruction cache and the L1 data cache of the pipelined LC-3b. It sits between the two L1 cache miss interfaces (their `pmem_*` sides) and the L2 request interface. It grants one whole line transaction at a time and routes `resp`/`rdata` back to the granted requester only. Contention is resolved round-robin, or by fixed D-cache priority when configured.

## Interface
Parameters:
- `ADDR_W`, 16: byte address width (`lc3b_word`).
- `LINE_W`, 128: cache line width (`lc3b_cache_size`).

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_pmem_address` in ADDR_W: I-cache miss line address.
- `i_pmem_read` in 1: I-cache line read request.
- `i_pmem_write` in 1: I-cache line write request (unused by the I-cache, but still arbitrated).
- `i_pmem_wdata` in LINE_W: I-cache writeback line.
- `i_pmem_rdata` out LINE_W: line returned to the I-cache.
- `i_pmem_resp` out 1: I-cache transaction complete.
- `d_pmem_address`, `d_pmem_read`, `d_pmem_write`, `d_pmem_wdata`, `d_pmem_rdata`, `d_pmem_resp`: same as the `i_` ports, for the D-cache.
- `l2_address` out ADDR_W: to L2.
- `l2_read` out 1: to L2.
- `l2_write` out 1: to L2.
- `l2_wdata` out LINE_W: to L2.
- `l2_rdata` in LINE_W: line from L2.
- `l2_resp` in 1: L2 transaction complete.
- `arb_grant` out 2: one-hot current owner; [0]=I, [1]=D; 00 when idle.

## Operation
- Request definitions: `req_i = i_pmem_read | i_pmem_write`, and `req_d` likewise.
- Requesters hold address, read, write and wdata stable from assertion until they see their `resp`.
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - `req_i` only: go to SERVE_I.
  - `req_d` only: go to SERVE_D.
  - Both: the winner is the one not in `last_grant`, a 1-bit register (round-robin).
  - Neither: stay in IDLE.
- SERVE_x:
  - The `l2_*` outputs are driven combinationally from requester x's live inputs.
  - If x asserts read and write together, `l2_write` wins and `l2_read` is forced to 0.
  - On `l2_resp`=1, drive `x_pmem_resp`=1 and `x_pmem_rdata`=`l2_rdata` in the same cycle. Next state is IDLE, and `last_grant` becomes x.
- Abort: in SERVE_x, if `req_x`=0 and `l2_resp`=0, go to IDLE next cycle. `last_grant` is not updated.
- A non-granted requester always sees `resp`=0 and `rdata`=0.
- `l2_resp` arriving in IDLE is ignored and is not forwarded.

## Timing
- Reset (asynchronous, on `rst_n`=0):
  - State IDLE.
  - `last_grant`=I, so the D-cache wins the first tie.
  - `arb_grant`=00.
  - All `l2_*` outputs and all `i_`/`d_` `resp` and `rdata` outputs are 0.
- Arbitration latency: a request seen in IDLE at edge N asserts `l2_read` or `l2_write` in cycle N+1.
- Total miss latency is the L2 latency plus 1 cycle.
- Response forwarding is zero-latency: `resp` and `rdata` are combinational from `l2_resp` and `l2_rdata` while in SERVE.
- Back-to-back grants: the cycle after `resp` is always IDLE. A waiting requester is granted at the end of that cycle. Minimum gap between two L2 transactions is one idle cycle.
- The requester drops its read/write on the edge after `resp`. The arbiter is in IDLE by then, so no duplicate request reaches L2.
- Reset asserted mid-transaction: outputs go to 0 immediately and the in-flight transaction is abandoned. The L2 must also be reset.

## Configuration
- `ARB_FIXED_DPRIO_EN` defined:
  - On simultaneous requests in IDLE, the D-cache always wins.
  - The `last_grant` register is not instantiated.
- Not defined: round-robin as described in Operation.

## Test plan
- Lone I-cache read:
  - Stimulus: `i_pmem_read`=1, `i_pmem_address`=0x1230. L2 returns `l2_rdata`=0x…CAFE with `l2_resp` 3 cycles after `l2_read` rises.
  - Required: `l2_read` rises 1 cycle after the request; `i_pmem_resp` is a 1-cycle pulse with `rdata`=0x…CAFE; `d_pmem_resp` stays 0; `arb_grant` goes 01 then 00.
- Simultaneous requests after reset:
  - Stimulus: I read at 0x0040 and D write at 0x8000, same cycle.
  - Required: D is served first (`l2_write`=1, `l2_address`=0x8000). Then I is served with `l2_address`=0x0040, after exactly one idle cycle.
- Round-robin fairness:
  - Stimulus: both requesters reassert immediately after every `resp`, for 6 transactions.
  - Required: grants alternate D, I, D, I, D, I.
  - With `ARB_FIXED_DPRIO_EN`: all 6 transactions go to D and I is starved.
- Abort:
  - Stimulus: grant I, then drop `i_pmem_read` before `l2_resp`.
  - Required: FSM is in IDLE next cycle; `l2_read`=0; a pending D request is granted the cycle after.
- Reset mid-operation:
  - Stimulus: pull `rst_n` low while in SERVE_D with `l2_write`=1.
  - Required: `l2_write`, `arb_grant` and both `resp` outputs are 0 asynchronously. After release, the first tie goes to D.
